// File: rtl/spike_rate_decoder_pkg.sv
// Shared types and helpers for the spike rate decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spike_dec_pkg;

  // Default width of the rate counter, ISI counter and window length.
  localparam int CNT_W_DEFAULT = 8;

  // Window FSM: IDLE until the first enabled cycle, then RUN forever.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } win_state_t;

  // ISI FSM: nothing to measure until the first edge has been seen.
  typedef enum logic {
    WAIT_FIRST = 1'b0,
    MEASURE    = 1'b1
  } isi_state_t;

  // Increment that sticks at lim instead of wrapping.
  function automatic int unsigned sat_inc(input int unsigned v, input int unsigned lim);
    return (v >= lim) ? lim : v + 32'd1;
  endfunction

endpackage

// File: rtl/spike_rate_decoder_edge_detect.sv
// Rising-edge detector for the neuron spike line; optional 2-flop synchronizer (SPIKE_DEC_SYNC_EN).
// Latency: edge is combinational from the spike level (plus 2 enabled cycles when synchronized).
// Backpressure: none; ena low freezes the synchronizer and the prev register.
module spike_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic spike_in,
  output logic spike_edge
);

  logic spike_lvl;
  logic prev;

`ifdef SPIKE_DEC_SYNC_EN
  logic sync_q1;
  logic sync_q2;

  // Two-flop synchronizer; frozen with the rest of the state when disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else if (ena) begin
      sync_q1 <= spike_in;
      sync_q2 <= sync_q1;
    end
  end

  assign spike_lvl = sync_q2;
`else
  assign spike_lvl = spike_in;
`endif

  // Previous spike level; reset to 0 so a level held through reset reads as an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= 1'b0;
    end else if (ena) begin
      prev <= spike_lvl;
    end
  end

  // A level held high for several cycles produces a single edge.
  assign spike_edge = ena & spike_lvl & ~prev;

endmodule

// File: rtl/spike_rate_decoder.sv
// Decodes a spike line into per-window spike counts and inter-spike intervals (SPIKE_DEC_SYNC_EN adds input sync).
// Latency: rate_out/isi_out update on the clock after the deciding cycle; valids pulse in the next enabled cycle.
// Backpressure: none; ena low freezes all state and holds back valid pulses until re-enabled.
module spike_rate_decoder
  import spike_dec_pkg::*;
#(
  parameter int          CNT_W   = CNT_W_DEFAULT,
  parameter int unsigned ISI_SAT = 2**CNT_W - 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             spike_in,
  input  logic [CNT_W-1:0] window_len,
  output logic [CNT_W-1:0] rate_out,
  output logic             rate_valid,
  output logic [CNT_W-1:0] isi_out,
  output logic             isi_valid,
  output logic             isi_ovf,
  output logic             busy
);

  localparam int unsigned          ACC_MAX   = 2**CNT_W - 1;
  localparam logic [CNT_W-1:0]     ISI_SAT_V = CNT_W'(ISI_SAT);

  logic spike_edge;

  spike_edge_detect u_edge (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .spike_in  (spike_in),
    .spike_edge(spike_edge)
  );

  // ---------------------------------------------------------------------------
  // Window FSM state
  // ---------------------------------------------------------------------------
  win_state_t       win_state;
  logic [CNT_W:0]   win_len;    // one extra bit so a zero setting can mean 2**CNT_W
  logic [CNT_W-1:0] wcnt;
  logic [CNT_W-1:0] acc;
  logic             rate_pend;

  logic [CNT_W:0]   len_sel;
  logic             win_last;
  logic [CNT_W-1:0] acc_next;

  // Window length as it will be latched at the next window start.
  always_comb begin
    len_sel = {1'b0, window_len};
    if (window_len == '0) begin
      len_sel = {1'b1, {CNT_W{1'b0}}};
    end
  end

  // Last cycle of the window, and the count including this cycle's edge.
  always_comb begin
    win_last = ({1'b0, wcnt} == (win_len - 1'b1));
    acc_next = acc;
    if (spike_edge) begin
      acc_next = CNT_W'(sat_inc(32'(acc), ACC_MAX));
    end
  end

  // Back-to-back windows: the last cycle publishes the count and starts the next window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_state <= IDLE;
      win_len   <= '0;
      wcnt      <= '0;
      acc       <= '0;
      rate_out  <= '0;
      rate_pend <= 1'b0;
    end else if (ena) begin
      rate_pend <= 1'b0;
      case (win_state)
        IDLE: begin
          win_state <= RUN;
          win_len   <= len_sel;
          wcnt      <= '0;
          acc       <= '0;
        end
        RUN: begin
          if (win_last) begin
            rate_out  <= acc_next;
            rate_pend <= 1'b1;
            acc       <= '0;
            wcnt      <= '0;
            win_len   <= len_sel;
          end else begin
            acc  <= acc_next;
            wcnt <= wcnt + 1'b1;
          end
        end
        default: win_state <= IDLE;
      endcase
    end
  end

  // A pending pulse is only shown in an enabled cycle; otherwise it waits.
  assign rate_valid = rate_pend & ena;
  assign busy       = (win_state == RUN);

  // ---------------------------------------------------------------------------
  // ISI FSM state
  // ---------------------------------------------------------------------------
  isi_state_t       isi_state;
  logic [CNT_W-1:0] icnt;
  logic             isi_pend;
  logic [CNT_W-1:0] icnt_inc;

  // Interval counter step, pinned at the saturation value.
  always_comb begin
    icnt_inc = CNT_W'(sat_inc(32'(icnt), ISI_SAT));
  end

  // Measures enabled cycles between successive edges; the first edge only arms it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      isi_state <= WAIT_FIRST;
      icnt      <= '0;
      isi_out   <= '0;
      isi_pend  <= 1'b0;
      isi_ovf   <= 1'b0;
    end else if (ena) begin
      isi_pend <= 1'b0;
      case (isi_state)
        WAIT_FIRST: begin
          if (spike_edge) begin
            isi_state <= MEASURE;
            icnt      <= CNT_W'(1);
          end
        end
        MEASURE: begin
          if (spike_edge) begin
            isi_out  <= icnt;
            isi_pend <= 1'b1;
            icnt     <= CNT_W'(1);
          end else begin
            icnt <= icnt_inc;
            if (icnt_inc == ISI_SAT_V) begin
              isi_ovf <= 1'b1;
            end
          end
        end
        default: isi_state <= WAIT_FIRST;
      endcase
    end
  end

  assign isi_valid = isi_pend & ena;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench for spike_rate_decoder with a scoreboard of expected valid pulses.
// Latency: n/a.
// Backpressure: n/a.
module tb_spike_rate_decoder;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         ena;
  logic         spike_in;
  logic [W-1:0] window_len;
  logic [W-1:0] rate_out;
  logic         rate_valid;
  logic [W-1:0] isi_out;
  logic         isi_valid;
  logic         isi_ovf;
  logic         busy;

  spike_rate_decoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .spike_in  (spike_in),
    .window_len(window_len),
    .rate_out  (rate_out),
    .rate_valid(rate_valid),
    .isi_out   (isi_out),
    .isi_valid (isi_valid),
    .isi_ovf   (isi_ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int cyc;
    int val;
  } exp_t;

  exp_t rate_q[$];
  exp_t isi_q[$];
  exp_t e_r;
  exp_t e_i;

  // Reference state: edge timestamps in enabled cycles, pending pulses.
  int   en_cnt;
  int   last_e;
  logic armed;
  logic prev_m;
  logic sd1;
  logic sd2;
  logic e_m;
  logic rate_pend;
  int   rate_pend_val;
  logic isi_pend;
  int   isi_pend_val;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, expv);
    end
  endtask

  task automatic reset_model();
    en_cnt    = 0;
    last_e    = 0;
    armed     = 1'b0;
    prev_m    = 1'b0;
    sd1       = 1'b0;
    sd2       = 1'b0;
    e_m       = 1'b0;
    rate_pend = 1'b0;
    isi_pend  = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_rate_out"}, rate_out, 0);
    check({tag, "_rate_valid"}, rate_valid, 0);
    check({tag, "_isi_out"}, isi_out, 0);
    check({tag, "_isi_valid"}, isi_valid, 0);
    check({tag, "_isi_ovf"}, isi_ovf, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  // Drive one clock cycle; pending pulses become expectations in the first enabled cycle.
  task automatic drive(input logic s, input logic en);
    logic eff;
    int   d;
    spike_in = s;
    ena      = en;
    e_m      = 1'b0;
    if (en) begin
      if (rate_pend) begin
        rate_q.push_back('{cyc, rate_pend_val});
        rate_pend = 1'b0;
      end
      if (isi_pend) begin
        isi_q.push_back('{cyc, isi_pend_val});
        isi_pend = 1'b0;
      end
      en_cnt++;
`ifdef SPIKE_DEC_SYNC_EN
      eff = sd2;
      sd2 = sd1;
      sd1 = s;
`else
      eff = s;
`endif
      e_m    = eff & ~prev_m;
      prev_m = eff;
      if (e_m) begin
        if (armed) begin
          d            = en_cnt - last_e;
          isi_pend     = 1'b1;
          isi_pend_val = (d > 255) ? 255 : d;
        end
        armed  = 1'b1;
        last_e = en_cnt;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // One window of L enabled cycles; off marks disabled cycles by real cycle index.
  task automatic window(input int L, input logic [255:0] pat, input logic [255:0] off, input int nxt);
    int i;
    int k;
    int cnt;
    i   = 0;
    k   = 0;
    cnt = 0;
    while (i < L && k < 512) begin
      if (k < 256 && off[k]) begin
        drive(1'($urandom_range(0, 1)), 1'b0);
      end else begin
        window_len = (i == L - 1) ? W'(nxt) : W'($urandom);
        drive(pat[i], 1'b1);
        if (e_m) cnt++;
        if (i == L - 1) begin
          rate_pend     = 1'b1;
          rate_pend_val = (cnt > 255) ? 255 : cnt;
        end
        i++;
      end
      k++;
    end
  endtask

  // Scoreboard: every valid pulse must match the oldest expectation in value and cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (rate_q.size() != 0 && rate_q[0].cyc < cyc) begin
        e_r = rate_q.pop_front();
        check("rate_missing", cyc, e_r.cyc);
      end
      if (isi_q.size() != 0 && isi_q[0].cyc < cyc) begin
        e_i = isi_q.pop_front();
        check("isi_missing", cyc, e_i.cyc);
      end
      if (rate_valid !== 1'b0) begin
        check("rate_valid_expected", 32'(rate_q.size() != 0), 1);
        if (rate_q.size() != 0) begin
          e_r = rate_q.pop_front();
          check("rate_value", rate_out, e_r.val);
          check("rate_cycle", cyc, e_r.cyc);
        end
      end
      if (isi_valid !== 1'b0) begin
        check("isi_valid_expected", 32'(isi_q.size() != 0), 1);
        if (isi_q.size() != 0) begin
          e_i = isi_q.pop_front();
          check("isi_value", isi_out, e_i.val);
          check("isi_cycle", cyc, e_i.cyc);
        end
      end
    end
  end

  logic [255:0] pat;
  logic [255:0] off;

  initial begin
    rst_n      = 1'b0;
    ena        = 1'b0;
    spike_in   = 1'b0;
    window_len = W'(10);
    reset_model();
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");

    // Release; the first enabled cycle is the IDLE cycle.
    rst_n = 1'b1;
    drive(1'b0, 1'b1);
    check("busy_after_release", busy, 1);

    pat = '0;
    pat[1] = 1'b1;
    pat[5] = 1'b1;
    pat[9] = 1'b1;
    window(10, pat, '0, 10);
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b1);
`ifndef SPIKE_DEC_SYNC_EN
    check("pre_reset_rate", rate_out, 3);
`endif
    check("pre_reset_isi", isi_out, 4);

    // Asynchronous reset in mid-window with the spike line high.
    spike_in = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("async_reset");
    reset_model();
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n      = 1'b1;
    window_len = W'(10);
    drive(1'b1, 1'b1);
    check("busy_after_rerelease", busy, 1);

    // Rate count: three spikes per 10-cycle window, one on the last cycle.
    window(10, pat, '0, 10);
    window(10, pat, '0, 10);
    window(10, pat, '0, 10);
    window(10, pat, '0, 8);
`ifndef SPIKE_DEC_SYNC_EN
    check("rate_count", rate_out, 3);
`endif

    // Held level counts once.
    pat = '0;
    for (int j = 1; j <= 5; j++) pat[j] = 1'b1;
    window(8, pat, '0, 32);
`ifndef SPIKE_DEC_SYNC_EN
    check("held_level", rate_out, 1);
`endif

    // ISI: edges at 0, 7, 20.
    pat = '0;
    pat[0]  = 1'b1;
    pat[7]  = 1'b1;
    pat[20] = 1'b1;
    window(32, pat, '0, 256);
    check("isi_13", isi_out, 13);
    check("isi_no_ovf", isi_ovf, 0);

    // 256-cycle window with a spike every second cycle.
    pat = '0;
    for (int j = 0; j < 256; j += 2) pat[j] = 1'b1;
    window(256, pat, '0, 256);
`ifndef SPIKE_DEC_SYNC_EN
    check("rate_128", rate_out, 128);
`endif
    window(256, '0, '0, 256);
    window(256, '0, '0, 10);
    check("isi_ovf_set", isi_ovf, 1);
    pat = '0;
    pat[0] = 1'b1;
    window(10, pat, '0, 10);
    check("isi_saturated", isi_out, 255);
    check("isi_ovf_sticky", isi_ovf, 1);

    // Enable gating: 5 disabled cycles mid-window, then disabled right after a window end.
    pat = '0;
    pat[2] = 1'b1;
    pat[6] = 1'b1;
    off = '0;
    for (int j = 3; j <= 7; j++) off[j] = 1'b1;
    window(10, pat, off, 10);
    check("ena_gated_rate", rate_out, 2);
    pat = '0;
    pat[3] = 1'b1;
    off = '0;
    off[0] = 1'b1;
    off[1] = 1'b1;
    window(10, pat, off, 10);
    check("ena_delayed_rate", rate_out, 1);

    repeat (4) drive(1'b0, 1'b1);
    check("rate_queue_drained", rate_q.size(), 0);
    check("isi_queue_drained", isi_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
